// File: rtl/io_trap_ctrl.sv
// ---------------------------------------------------------------------------
// io_trap_ctrl
//
// I/O trap controller for the Nabu MegaMapper CPLD. When user code performs
// an I/O cycle to a port whose 16-port group is masked, the physical access
// is suppressed (io_block), the port/data/direction are latched and an NMI
// pulse is sent to the supervisor. The trap is released when the opcode
// tracker reports RETN via a rising edge of last_isr_untrap.
//
// Optional feature macro: TRAP_IN_FAKE_EN
//   defined     : a trapped IN cycle reads 8'hFF (data_oe=1 during CAPTURE)
//   not defined : a trapped IN cycle leaves the bus floating
//
// Parameters:
//   CTRL_PORT   base of the 5-port supervisor window (CTRL_PORT..CTRL_PORT+4)
//   NMI_CYCLES  nmi_n low pulse width in clk cycles (1..255)
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   iorq_n, rd_n, wr_n, m1_n   Z80 bus strobes (already synchronous to clk)
//   addr[7:0], data_in[7:0]    Z80 address (A7..A0) and data bus
//   new_isr, last_isr_untrap,
//   io_direction               opcode tracker status (io_direction 1=IN)
//   ignore_next_isr            to opcode tracker
//   nmi_n                      Z80 NMI, active low
//   io_block                   suppresses physical I/O decode
//   trap_active                supervisor is handling a trap
//   data_out[7:0], data_oe     read-back data and its bus drive enable
//   dbg_state[1:0]             current FSM state (IDLE=0, CAPTURE=1,
//                              NMI=2, TRAPPED=3)
// ---------------------------------------------------------------------------
module io_trap_ctrl #(
    parameter logic [7:0] CTRL_PORT  = 8'h40,
    parameter int         NMI_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       m1_n,
    input  logic [7:0] addr,
    input  logic [7:0] data_in,
    input  logic       new_isr,
    input  logic       last_isr_untrap,
    input  logic       io_direction,
    output logic       ignore_next_isr,
    output logic       nmi_n,
    output logic       io_block,
    output logic       trap_active,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        NMI     = 2'd2,
        TRAPPED = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] mask_q, mask_d;
    logic [7:0]  trap_port_q, trap_port_d;
    logic [7:0]  trap_data_q, trap_data_d;
    logic        trap_dir_q, trap_dir_d;
    logic        dir_err_q, dir_err_d;
    logic [7:0]  nmi_cnt_q, nmi_cnt_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        untrap_prev_q, untrap_prev_d;

    logic        io_cycle;
    logic [7:0]  win_off;
    logic        in_win;
    logic        win_rd;
    logic        untrap_edge;
    logic        fake_rd;

    // The opcode tracker's new_isr is not needed by this block.
    logic        unused_new_isr;
    assign unused_new_isr = new_isr;

    // Interrupt acknowledge (iorq_n=0, m1_n=0) is not an I/O cycle.
    assign io_cycle    = !iorq_n && m1_n;
    assign win_off     = addr - CTRL_PORT;
    assign in_win      = (win_off < 8'd5);
    assign win_rd      = (state_q == TRAPPED) && io_cycle && !rd_n &&
                         (win_off >= 8'd2) && (win_off <= 8'd4);
    assign untrap_edge = last_isr_untrap && !untrap_prev_q;

    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        trap_port_d   = trap_port_q;
        trap_data_d   = trap_data_q;
        trap_dir_d    = trap_dir_q;
        dir_err_d     = dir_err_q;
        nmi_cnt_d     = nmi_cnt_q;
        data_out_d    = 8'h00;
        untrap_prev_d = last_isr_untrap;

        case (state_q)
            IDLE: begin
                if (io_cycle && mask_q[addr[7:4]]) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (iorq_n) begin
                    state_d   = NMI;
                    nmi_cnt_d = 8'd0;
                end
            end
            NMI: begin
                if (nmi_cnt_q == 8'(NMI_CYCLES - 1)) begin
                    state_d = TRAPPED;
                end else begin
                    nmi_cnt_d = nmi_cnt_q + 8'd1;
                end
            end
            TRAPPED: begin
                if (untrap_edge) begin
                    state_d = IDLE;
                end
                if (io_cycle && !wr_n) begin
                    if (win_off == 8'd0) mask_d[7:0]  = data_in;
                    if (win_off == 8'd1) mask_d[15:8] = data_in;
                end
                if (win_rd) begin
                    case (win_off)
                        8'd2:    data_out_d = trap_port_q;
                        8'd3:    data_out_d = trap_data_q;
                        default: data_out_d = {5'b0, dir_err_q, trap_dir_q, 1'b1};
                    endcase
                end
            end
        endcase

        // Capture the trapped access on the detecting clock and on every
        // following clock of the same cycle, so the last sampled bus values win.
        if ((state_q == IDLE && state_d == CAPTURE) ||
            (state_q == CAPTURE && io_cycle)) begin
            trap_port_d = addr;
            trap_dir_d  = io_direction;
            trap_data_d = !wr_n ? data_in : 8'h00;
            dir_err_d   = (io_direction != !rd_n);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= TRAPPED;
            mask_q        <= 16'h0000;
            trap_port_q   <= 8'h00;
            trap_data_q   <= 8'h00;
            trap_dir_q    <= 1'b0;
            dir_err_q     <= 1'b0;
            nmi_cnt_q     <= 8'h00;
            data_out_q    <= 8'h00;
            // Treat the line as already high so a level held across reset
            // is never mistaken for a RETN edge.
            untrap_prev_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            trap_port_q   <= trap_port_d;
            trap_data_q   <= trap_data_d;
            trap_dir_q    <= trap_dir_d;
            dir_err_q     <= dir_err_d;
            nmi_cnt_q     <= nmi_cnt_d;
            data_out_q    <= data_out_d;
            untrap_prev_q <= untrap_prev_d;
        end
    end

`ifdef TRAP_IN_FAKE_EN
    assign fake_rd  = (state_q == CAPTURE) && io_cycle && !rd_n;
    assign data_out = fake_rd ? 8'hFF : data_out_q;
`else
    assign fake_rd  = 1'b0;
    assign data_out = data_out_q;
`endif

    assign data_oe         = win_rd || fake_rd;
    assign io_block        = (state_q == CAPTURE) ||
                             ((state_q == TRAPPED) && io_cycle && in_win);
    assign nmi_n           = (state_q != NMI);
    assign trap_active     = (state_q == TRAPPED);
    assign ignore_next_isr = (state_q == CAPTURE) || (state_q == NMI);
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_io_trap_ctrl.sv
module tb_io_trap_ctrl;

  localparam int S_STATE  = 0;
  localparam int S_ACTIVE = 1;
  localparam int S_NMI    = 2;
  localparam int S_BLOCK  = 3;
  localparam int S_OE     = 4;
  localparam int S_DOUT   = 5;
  localparam int S_IGN    = 6;

  typedef struct {
    string      name;
    int         sig;
    logic [7:0] exp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iorq_n, rd_n, wr_n, m1_n;
  logic [7:0] addr, data_in;
  logic       new_isr, last_isr_untrap, io_direction;
  logic       ignore_next_isr, nmi_n, io_block, trap_active, data_oe;
  logic [7:0] data_out;
  logic [1:0] dbg_state;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  io_trap_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .iorq_n         (iorq_n),
    .rd_n           (rd_n),
    .wr_n           (wr_n),
    .m1_n           (m1_n),
    .addr           (addr),
    .data_in        (data_in),
    .new_isr        (new_isr),
    .last_isr_untrap(last_isr_untrap),
    .io_direction   (io_direction),
    .ignore_next_isr(ignore_next_isr),
    .nmi_n          (nmi_n),
    .io_block       (io_block),
    .trap_active    (trap_active),
    .data_out       (data_out),
    .data_oe        (data_oe),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard monitor ----------------
  function automatic logic [7:0] sample(input int sig);
    case (sig)
      S_STATE:  return {6'b0, dbg_state};
      S_ACTIVE: return {7'b0, trap_active};
      S_NMI:    return {7'b0, nmi_n};
      S_BLOCK:  return {7'b0, io_block};
      S_OE:     return {7'b0, data_oe};
      S_DOUT:   return data_out;
      default:  return {7'b0, ignore_next_isr};
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t       it;
    logic [7:0] act;
    while (exp_q.size() > 0) begin
      it  = exp_q.pop_front();
      act = sample(it.sig);
      checks++;
      if (act !== it.exp) begin
        failures++;
        $display("FAIL %s: got %0h expected %0h at %0t", it.name, act, it.exp, $time);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sig(input int sig, input logic [7:0] v, input string nm);
    exp_t it;
    it.name = nm;
    it.sig  = sig;
    it.exp  = v;
    exp_q.push_back(it);
  endtask

  task automatic check_now(input int sig, input logic [7:0] v, input string nm);
    logic [7:0] act;
    act = sample(sig);
    checks++;
    if (act !== v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, v, $time);
    end
  endtask

  task automatic wait_state(input logic [1:0] st, input int max_cyc, input string nm);
    int n;
    n = 0;
    while (dbg_state !== st && n < max_cyc) begin
      cyc();
      n++;
    end
    checks++;
    if (dbg_state !== st) begin
      failures++;
      $display("FAIL %s: wait for state %0d expired after %0d clocks at %0t", nm, st, max_cyc, $time);
    end
  endtask

  task automatic bus_idle();
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
    addr = 8'h00; data_in = 8'h00; io_direction = 1'b0;
  endtask

  task automatic sup_read(input logic [7:0] a, input logic [7:0] v, input string nm);
    cyc();
    addr = a; iorq_n = 1'b0; rd_n = 1'b0; io_direction = 1'b1;
    expect_sig(S_OE, 8'd1, {nm, "_oe"});
    expect_sig(S_BLOCK, 8'd1, {nm, "_block"});
    cyc();
    expect_sig(S_DOUT, v, nm);
    cyc();
    bus_idle();
  endtask

  task automatic sup_write(input logic [7:0] a, input logic [7:0] d);
    cyc();
    addr = a; data_in = d; iorq_n = 1'b0; wr_n = 1'b0;
    expect_sig(S_BLOCK, 8'd1, "win_wr_block");
    cyc();
    bus_idle();
  endtask

  // After the trapped access has ended: nmi_n low for exactly 8 clocks.
  task automatic nmi_pulse(input string nm);
    expect_sig(S_NMI, 8'd1, {nm, "_nmi_before"});
    for (int i = 0; i < 8; i++) begin
      cyc();
      expect_sig(S_NMI, 8'd0, {nm, "_nmi_low"});
      expect_sig(S_IGN, 8'd1, {nm, "_ignore"});
    end
    cyc();
    expect_sig(S_NMI, 8'd1, {nm, "_nmi_end"});
    expect_sig(S_ACTIVE, 8'd1, {nm, "_trapped"});
  endtask

  task automatic untrap(input string nm);
    cyc();
    last_isr_untrap = 1'b0;
    cyc();
    last_isr_untrap = 1'b1;
    expect_sig(S_ACTIVE, 8'd1, {nm, "_still_active"});
    cyc();
    expect_sig(S_ACTIVE, 8'd0, {nm, "_released"});
    expect_sig(S_STATE, 8'd0, {nm, "_idle"});
    last_isr_untrap = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; new_isr = 1'b0; last_isr_untrap = 1'b0;
    bus_idle();
    repeat (3) cyc();
    check_now(S_STATE,  8'd3, "rst_state");
    check_now(S_ACTIVE, 8'd1, "rst_active");
    check_now(S_NMI,    8'd1, "rst_nmi");
    check_now(S_BLOCK,  8'd0, "rst_block");
    check_now(S_OE,     8'd0, "rst_oe");
    check_now(S_DOUT,   8'd0, "rst_dout");
    check_now(S_IGN,    8'd0, "rst_ignore");
    rst_n = 1'b1;

    // Boot trap: status read, arm group 2 (ports 20h-2Fh), release.
    sup_read(8'h44, 8'h01, "boot_status");
    sup_write(8'h40, 8'h04);
    sup_write(8'h41, 8'h00);
    untrap("boot");
    wait_state(2'd0, 4, "boot_wait_idle");

    // Trapped OUT (2Ah) = 5Ch.
    cyc();
    addr = 8'h2A; data_in = 8'h5C; iorq_n = 1'b0; wr_n = 1'b0; io_direction = 1'b0;
    expect_sig(S_BLOCK, 8'd0, "out_block_lat0");
    cyc();
    expect_sig(S_BLOCK, 8'd1, "out_block_lat1");
    expect_sig(S_IGN,   8'd1, "out_ignore");
    cyc();
    bus_idle();
    nmi_pulse("out2a");
    sup_read(8'h42, 8'h2A, "out_port");
    sup_read(8'h43, 8'h5C, "out_data");
    sup_read(8'h44, 8'h01, "out_status");

    // Masked port during TRAPPED is not trapped.
    cyc();
    addr = 8'h2A; data_in = 8'h11; iorq_n = 1'b0; wr_n = 1'b0;
    expect_sig(S_BLOCK, 8'd0, "trapped_out_block");
    cyc();
    expect_sig(S_BLOCK, 8'd0, "trapped_out_block2");
    expect_sig(S_STATE, 8'd3, "trapped_out_state");
    cyc();
    bus_idle();
    untrap("out");

    // Trapped IN (20h) with io_direction=1.
    cyc();
    addr = 8'h20; iorq_n = 1'b0; rd_n = 1'b0; io_direction = 1'b1;
    cyc();
    expect_sig(S_BLOCK, 8'd1, "in_block");
`ifdef TRAP_IN_FAKE_EN
    expect_sig(S_OE,   8'd1,  "in_fake_oe");
    expect_sig(S_DOUT, 8'hFF, "in_fake_data");
`else
    expect_sig(S_OE,   8'd0,  "in_float_oe");
`endif
    cyc();
    bus_idle();
    nmi_pulse("in20");
    sup_read(8'h42, 8'h20, "in_port");
    sup_read(8'h43, 8'h00, "in_data");
    sup_read(8'h44, 8'h03, "in_status");
    untrap("in");

    // Unmasked OUT (50h) and interrupt acknowledge on 20h: no trap.
    cyc();
    addr = 8'h50; data_in = 8'hAA; iorq_n = 1'b0; wr_n = 1'b0;
    cyc();
    expect_sig(S_BLOCK, 8'd0, "unmasked_block");
    expect_sig(S_NMI,   8'd1, "unmasked_nmi");
    cyc();
    bus_idle();
    addr = 8'h20; iorq_n = 1'b0; m1_n = 1'b0;
    cyc();
    expect_sig(S_BLOCK, 8'd0, "inta_block");
    expect_sig(S_STATE, 8'd0, "inta_state");
    cyc();
    bus_idle();
    cyc();
    expect_sig(S_NMI, 8'd1, "inta_nmi");

    // Direction error (IN with io_direction=0), untrap held high throughout.
    last_isr_untrap = 1'b1;
    addr = 8'h2F; iorq_n = 1'b0; rd_n = 1'b0; io_direction = 1'b0;
    cyc();
    cyc();
    bus_idle();
    nmi_pulse("direrr");
    sup_read(8'h44, 8'h05, "direrr_status");
    repeat (3) cyc();
    expect_sig(S_ACTIVE, 8'd1, "held_high_active");
    untrap("direrr");

    // Reset on the 3rd NMI clock.
    cyc();
    addr = 8'h2A; data_in = 8'h77; iorq_n = 1'b0; wr_n = 1'b0;
    cyc();
    cyc();
    bus_idle();
    cyc();
    cyc();
    cyc();
    expect_sig(S_NMI, 8'd0, "pre_reset_nmi");
    rst_n = 1'b0;
    cyc();
    expect_sig(S_NMI,    8'd1, "midrst_nmi");
    expect_sig(S_ACTIVE, 8'd1, "midrst_active");
    expect_sig(S_IGN,    8'd0, "midrst_ignore");
    rst_n = 1'b1;
    untrap("postrst");
    wait_state(2'd0, 4, "postrst_wait_idle");
    // Mask cleared by reset: port 2Ah no longer traps.
    cyc();
    addr = 8'h2A; data_in = 8'h33; iorq_n = 1'b0; wr_n = 1'b0;
    cyc();
    expect_sig(S_BLOCK, 8'd0, "mask_cleared_block");
    cyc();
    bus_idle();
    expect_sig(S_STATE, 8'd0, "mask_cleared_state");
    cyc();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
